// File: rtl/ex.sv
// Execute stage: logic/shift ALU plus a multi-cycle restoring divider for HI/LO.
// Latency: logic/shift results are combinational; divide ends 33 cycles after issue (2 cycles for divide-by-zero).
// Backpressure: stallreq_o holds the upstream pipeline until the divider reaches its END state.
module ex (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [2:0]  alusel_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stallreq_o
);

   localparam logic [7:0] OP_OR   = 8'b00100101;
   localparam logic [7:0] OP_AND  = 8'b00100100;
   localparam logic [7:0] OP_XOR  = 8'b00100110;
   localparam logic [7:0] OP_NOR  = 8'b00100111;
   localparam logic [7:0] OP_SLL  = 8'b01111100;
   localparam logic [7:0] OP_SRL  = 8'b00000010;
   localparam logic [7:0] OP_SRA  = 8'b00000011;
   localparam logic [7:0] OP_DIV  = 8'b00011010;
   localparam logic [7:0] OP_DIVU = 8'b00011011;

   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DIVZERO = 2'd1,
      S_ON      = 2'd2,
      S_END     = 2'd3
   } div_state_t;

   div_state_t  state, next_state;
   logic [5:0]  cnt;
   logic [31:0] divisor;
   logic [31:0] quo;       // holds the dividend at start, shifted out as quotient bits shift in
   logic [31:0] rem;
   logic        neg_quo;
   logic        neg_rem;

   logic        is_div;
   logic        is_signed;
   logic [31:0] abs1, abs2;
   logic [32:0] trial;
   logic [32:0] diff;
   logic [31:0] logic_res, shift_res;

   assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
   assign is_signed = (aluop_i == OP_DIV);
   assign abs1      = (is_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
   assign abs2      = (is_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

   // One restoring step: shift next dividend bit into the partial remainder and try a subtract.
   assign trial = {rem, quo[31]};
   assign diff  = trial - {1'b0, divisor};

   // Logic unit result; unknown opcodes give zero.
   always_comb begin
      logic_res = 32'd0;
      case (aluop_i)
         OP_OR:   logic_res = reg1_i | reg2_i;
         OP_AND:  logic_res = reg1_i & reg2_i;
         OP_XOR:  logic_res = reg1_i ^ reg2_i;
         OP_NOR:  logic_res = ~(reg1_i | reg2_i);
         default: logic_res = 32'd0;
      endcase
   end

   // Shift unit result: value in reg2, amount in reg1[4:0].
   always_comb begin
      shift_res = 32'd0;
      case (aluop_i)
         OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
         OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
         OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
         default: shift_res = 32'd0;
      endcase
   end

   // Divider state register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // Divider next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (is_div) next_state = (reg2_i == 32'd0) ? S_DIVZERO : S_ON;
         end
         S_DIVZERO: next_state = S_END;
         S_ON:      next_state = (cnt == 6'd31) ? S_END : S_ON;
         S_END:     next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   // Divider datapath: operands and result signs are captured only in IDLE so later input changes are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= 6'd0;
         divisor <= 32'd0;
         quo     <= 32'd0;
         rem     <= 32'd0;
         neg_quo <= 1'b0;
         neg_rem <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= 6'd0;
               if (is_div && reg2_i != 32'd0) begin
                  quo     <= abs1;
                  divisor <= abs2;
                  rem     <= 32'd0;
                  neg_quo <= is_signed && (reg1_i[31] != reg2_i[31]);
                  neg_rem <= is_signed && reg1_i[31];
               end
            end
            S_DIVZERO: begin
               quo     <= 32'd0;
               rem     <= 32'd0;
               neg_quo <= 1'b0;
               neg_rem <= 1'b0;
            end
            S_ON: begin
               cnt <= cnt + 6'd1;
               if (!diff[32]) begin
                  rem <= diff[31:0];
                  quo <= {quo[30:0], 1'b1};
               end else begin
                  rem <= trial[31:0];
                  quo <= {quo[30:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs: GPR result, HI/LO only in END, stall while a divide is pending; all forced to zero under reset.
   always_comb begin
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      wdata_o    = 32'd0;
      whilo_o    = 1'b0;
      hi_o       = 32'd0;
      lo_o       = 32'd0;
      stallreq_o = 1'b0;
      if (!rst) begin
         wd_o   = wd_i;
         wreg_o = wreg_i;
         case (alusel_i)
            SEL_LOGIC: wdata_o = logic_res;
            SEL_SHIFT: wdata_o = shift_res;
            default:   wdata_o = 32'd0;
         endcase
         case (state)
            S_IDLE:    stallreq_o = is_div;
            S_DIVZERO: stallreq_o = 1'b1;
            S_ON:      stallreq_o = 1'b1;
            S_END: begin
               whilo_o = 1'b1;
               lo_o    = neg_quo ? (~quo + 32'd1) : quo;
               hi_o    = neg_rem ? (~rem + 32'd1) : rem;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ex.md
EX -- requirements
Module: ex

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high (asserted level = `RESETABLE).
REQ-003 aluop_i  in  8  operation code from decode stage.
REQ-004 alusel_i  in  3  result class: 000 NOP, 001 LOGIC, 010 SHIFT.
REQ-005 reg1_i, reg2_i  in  32 each  operands from decode stage; for shifts reg1_i[4:0]=shift amount, reg2_i=value.
REQ-006 wd_i  in  5  destination register address; wreg_i  in  1  destination write enable.
REQ-007 wd_o  out  5  destination address, equals wd_i; wreg_o  out  1  write enable, equals wreg_i.
REQ-008 wdata_o  out  32  GPR result; also feeds decode-stage forwarding as ex_wdata_i.
REQ-009 whilo_o  out  1  HI/LO write enable; hi_o, lo_o  out  32 each  HI/LO values.
REQ-010 stallreq_o  out  1  request to freeze pc/if_id/id_ex while a divide runs.

Function
REQ-011 Opcodes SHALL be: OR 8'b00100101, AND 8'b00100100, XOR 8'b00100110, NOR 8'b00100111, SLL 8'b01111100, SRL 8'b00000010, SRA 8'b00000011, DIV 8'b00011010, DIVU 8'b00011011, NOP 8'b00000000.
REQ-012 LOGIC result SHALL be reg1 op reg2 (OR/AND/XOR/NOR), combinational, zero latency.
REQ-013 SHIFT result SHALL be reg2 shifted by reg1[4:0]: SLL zero-fill left, SRL zero-fill right, SRA sign-fill right; shift 0 returns reg2 unchanged.
REQ-014 wdata_o SHALL select LOGIC/SHIFT result by alusel_i; any other alusel_i or unknown aluop_i gives 0.
REQ-015 Divider FSM states SHALL be IDLE, DIVZERO, ON, END; reset state IDLE.
REQ-016 IDLE: on DIV/DIVU with reg2_i!=0 go ON, latch dividend/divisor (absolute values for DIV, raw for DIVU), clear counter; with reg2_i==0 go DIVZERO; else stay IDLE.
REQ-017 ON: one restoring shift-subtract step per cycle, counter +1; after the 32nd step go END.
REQ-018 DIVZERO: one cycle, force quotient=remainder=0, go END.
REQ-019 END: lo_o=quotient, hi_o=remainder, whilo_o=1 for exactly this cycle; next state IDLE.
REQ-020 DIV sign fix in END: quotient negated iff reg1 sign != reg2 sign; remainder takes dividend's sign; DIVU unsigned throughout.
REQ-021 stallreq_o SHALL be 1 combinationally in IDLE when a divide op is present, and in DIVZERO and ON; 0 in END and otherwise.
REQ-022 Latency: divide entering at cycle 0 gives whilo_o=1 at cycle 33 (by-zero: cycle 2); stallreq_o high cycles 0..32 (by-zero 0..1).
REQ-023 Operands SHALL be latched in IDLE only; input changes during ON/DIVZERO SHALL not affect the result.
REQ-024 whilo_o, hi_o, lo_o SHALL be 0 outside END; divide ops give wreg_o pass-through but wdata_o=0.
REQ-025 Overflow case DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 (wrap, no trap).

Reset
REQ-026 With rst=1 at an edge, FSM SHALL enter IDLE and clear counter, dividend, divisor, quotient/remainder registers, including mid-divide.
REQ-027 While rst=1 all outputs SHALL be 0: wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o.
REQ-028 Output in first cycle after rst deasserts SHALL depend only on current inputs (no stale divide result).

Verification
REQ-029 OR reg1=0x0000FF00, reg2=0x00F0F0F0, alusel=001, wd=5, wreg=1 -> same cycle wdata_o=0x00F0FFF0, wd_o=5, wreg_o=1, stallreq_o=0.
REQ-030 SRA reg1=4, reg2=0x80000010 -> wdata_o=0xF8000001; SRL same -> 0x08000001; SLL reg1=31, reg2=1 -> 0x80000000.
REQ-031 DIV reg1=0xFFFFFFF9 (-7), reg2=2 held under stall -> stallreq_o high 33 cycles, then one cycle whilo_o=1, lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
REQ-032 DIV reg2=0 -> stallreq_o 2 cycles, then whilo_o=1, hi_o=lo_o=0.
REQ-033 rst=1 at cycle 10 of a DIV -> next cycle all outputs 0, state IDLE; a following OR completes with zero latency.
REQ-034 Change reg1_i/reg2_i during ON -> result matches originally latched operands.
